// File: rtl/fifo_sel_arb_if.sv
// Bundles the request bits, release pulse and grant outputs of fifo_sel_arb.
// FIFO_SEL_STATS_EN adds the grant_cnt and preempt_flag signals.
interface fifo_sel_arb_if #(
    parameter int PORT_NUM = 4
) ();
    logic [PORT_NUM-1:0] fifo_sel_bits;
    logic                sel_release;
    logic [7:0]          fifo_sel_res_final;
    logic [PORT_NUM-1:0] sel_onehot;
    logic                sel_new;
`ifdef FIFO_SEL_STATS_EN
    logic [15:0]         grant_cnt;
    logic                preempt_flag;
`endif

    modport master (
        output fifo_sel_bits,
        output sel_release,
`ifdef FIFO_SEL_STATS_EN
        input  grant_cnt,
        input  preempt_flag,
`endif
        input  fifo_sel_res_final,
        input  sel_onehot,
        input  sel_new
    );

    modport slave (
        input  fifo_sel_bits,
        input  sel_release,
`ifdef FIFO_SEL_STATS_EN
        output grant_cnt,
        output preempt_flag,
`endif
        output fifo_sel_res_final,
        output sel_onehot,
        output sel_new
    );
endinterface

// File: rtl/fifo_sel_arb.sv
// Grants one of PORT_NUM FIFO requests at a time, holds it until release, then idles one cycle.
// Optional statistics outputs are enabled with the FIFO_SEL_STATS_EN macro.
module fifo_sel_arb #(
    parameter int PORT_NUM = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic            glb_clk,
    input  logic            glb_srst,
    fifo_sel_arb_if.slave   bus
);
    localparam int IW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [7:0]          res_q, res_d;
    logic [PORT_NUM-1:0] onehot_q, onehot_d;
    logic                new_q, new_d;
    logic                preempt;
    logic                end_grant;
    logic                win_valid;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       base;
    logic [IW-1:0]       off;
    logic [IW:0]         sum;
    logic [2*PORT_NUM-1:0] dbl;
    logic [PORT_NUM-1:0] rot;

    // Rotate the requests so the search origin sits at bit 0, then undo the rotation.
    always_comb begin
        base = (RR_MODE != 0) ? rr_ptr_q : '0;
        dbl  = {bus.fifo_sel_bits, bus.fifo_sel_bits};
        rot  = PORT_NUM'(dbl >> base);
        off  = '0;
        for (int j = PORT_NUM - 1; j >= 0; j--) begin
            if (rot[j]) off = IW'(j);
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IW+1)'(PORT_NUM)) sum = sum - (IW+1)'(PORT_NUM);
        win_idx   = IW'(sum);
        win_valid = |bus.fifo_sel_bits;
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        res_d     = res_q;
        onehot_d  = onehot_q;
        new_d     = 1'b0;
        preempt   = 1'b0;
        end_grant = 1'b0;
        case (state_q)
            GRANT: begin
                preempt   = (MAX_HOLD > 0) && (hold_q == HOLD_LAST)
                            && (|(bus.fifo_sel_bits & ~onehot_q));
                end_grant = !(|(bus.fifo_sel_bits & onehot_q)) || bus.sel_release || preempt;
                if (end_grant) begin
                    state_d  = GAP;
                    res_d    = 8'h00;
                    onehot_d = '0;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; only the entry path differs.
                if (win_valid) begin
                    state_d  = GRANT;
                    hold_d   = '0;
                    res_d    = {1'b1, 7'(win_idx)};
                    onehot_d = PORT_NUM'(1) << win_idx;
                    new_d    = 1'b1;
                    rr_ptr_d = (win_idx == IW'(PORT_NUM - 1)) ? '0 : win_idx + IW'(1);
                end else begin
                    state_d  = IDLE;
                    res_d    = 8'h00;
                    onehot_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge glb_clk) begin
        if (glb_srst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            res_q    <= 8'h00;
            onehot_q <= '0;
            new_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            res_q    <= res_d;
            onehot_q <= onehot_d;
            new_q    <= new_d;
        end
    end

    assign bus.fifo_sel_res_final = res_q;
    assign bus.sel_onehot         = onehot_q;
    assign bus.sel_new            = new_q;

`ifdef FIFO_SEL_STATS_EN
    logic [15:0] grant_cnt_q;
    logic        preempt_q;

    // The counter moves on the same edge that raises sel_new.
    always_ff @(posedge glb_clk) begin
        if (glb_srst) begin
            grant_cnt_q <= 16'h0000;
            preempt_q   <= 1'b0;
        end else begin
            if (new_d && grant_cnt_q != 16'hFFFF) grant_cnt_q <= grant_cnt_q + 16'h0001;
            preempt_q <= preempt;
        end
    end

    assign bus.grant_cnt    = grant_cnt_q;
    assign bus.preempt_flag = preempt_q;
`endif
endmodule

// File: tb/tb_fifo_sel_arb.sv
// Drives three arbiter configurations (round-robin, fixed priority, MAX_HOLD=3) with shared stimulus
// and compares each against a cycle-level reference model.
module tb_fifo_sel_arb;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] bits = '0;
    logic         rel = 1'b0;

    int checks   = 0;
    int failures = 0;

    int cfg_rr[3] = '{1, 0, 1};
    int cfg_mh[3] = '{0, 0, 3};

    int m_phase[3];
    int m_ptr[3];
    int m_hc[3];
    int m_gidx[3];
    int e_res[3];
    int e_one[3];
    int e_new[3];
    int e_cnt[3];
    int e_pre[3];

    int seq_rr[9] = '{'h80, 0, 'h81, 0, 'h82, 0, 'h83, 0, 'h80};
    int seq_fp[9] = '{'h80, 0, 'h80, 0, 'h80, 0, 'h80, 0, 'h80};
    int seq_mh[9] = '{'h80, 'h80, 'h80, 0, 'h81, 'h81, 'h81, 0, 'h80};

    fifo_sel_arb_if #(.PORT_NUM(N)) bus_rr ();
    fifo_sel_arb_if #(.PORT_NUM(N)) bus_fp ();
    fifo_sel_arb_if #(.PORT_NUM(N)) bus_mh ();

    assign bus_rr.fifo_sel_bits = bits;
    assign bus_fp.fifo_sel_bits = bits;
    assign bus_mh.fifo_sel_bits = bits;
    assign bus_rr.sel_release   = rel;
    assign bus_fp.sel_release   = rel;
    assign bus_mh.sel_release   = rel;

    fifo_sel_arb #(.PORT_NUM(N), .RR_MODE(1), .MAX_HOLD(0)) dut_rr (
        .glb_clk(clk), .glb_srst(rst), .bus(bus_rr));
    fifo_sel_arb #(.PORT_NUM(N), .RR_MODE(0), .MAX_HOLD(0)) dut_fp (
        .glb_clk(clk), .glb_srst(rst), .bus(bus_fp));
    fifo_sel_arb #(.PORT_NUM(N), .RR_MODE(1), .MAX_HOLD(3)) dut_mh (
        .glb_clk(clk), .glb_srst(rst), .bus(bus_mh));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour: one grant at a time, one idle cycle after each grant ends.
    task automatic model_step(input logic [N-1:0] b, input logic r, input logic s);
        for (int c = 0; c < 3; c++) begin
            if (s) begin
                m_phase[c] = 0; m_ptr[c] = 0; m_hc[c] = 0;
                e_res[c] = 0; e_one[c] = 0; e_new[c] = 0; e_cnt[c] = 0; e_pre[c] = 0;
            end else begin
                e_new[c] = 0;
                e_pre[c] = 0;
                if (m_phase[c] == 1) begin
                    logic [N-1:0] gmask;
                    bit live, others, pre;
                    gmask  = N'(1) << m_gidx[c];
                    live   = (b & gmask) != 0;
                    others = (b & ~gmask) != 0;
                    pre    = (cfg_mh[c] > 0) && (m_hc[c] == cfg_mh[c] - 1) && others;
                    if (!live || r || pre) begin
                        m_phase[c] = 2;
                        e_res[c] = 0;
                        e_one[c] = 0;
                        e_pre[c] = pre ? 1 : 0;
                    end else begin
                        m_hc[c]++;
                    end
                end else if (b != 0) begin
                    int w;
                    int start;
                    w = -1;
                    start = (cfg_rr[c] != 0) ? m_ptr[c] : 0;
                    for (int k = 0; k < N; k++) begin
                        int j;
                        j = (start + k) % N;
                        if (w < 0 && ((b >> j) & N'(1)) != 0) w = j;
                    end
                    m_phase[c] = 1;
                    m_gidx[c]  = w;
                    m_hc[c]    = 0;
                    e_res[c]   = 'h80 + w;
                    e_one[c]   = 1 << w;
                    e_new[c]   = 1;
                    if (e_cnt[c] < 65535) e_cnt[c]++;
                    m_ptr[c]   = (w + 1) % N;
                end else begin
                    m_phase[c] = 0;
                    e_res[c] = 0;
                    e_one[c] = 0;
                end
            end
        end
    endtask

    task automatic compare_one(input string name, input int c, input logic [7:0] res,
                               input logic [N-1:0] one, input logic nw);
        checkOutput({name, "_res"}, 32'(res), e_res[c]);
        checkOutput({name, "_onehot"}, 32'(one), e_one[c]);
        checkOutput({name, "_new"}, 32'(nw), e_new[c]);
    endtask

    task automatic compare_all();
        compare_one("rr", 0, bus_rr.fifo_sel_res_final, bus_rr.sel_onehot, bus_rr.sel_new);
        compare_one("fp", 1, bus_fp.fifo_sel_res_final, bus_fp.sel_onehot, bus_fp.sel_new);
        compare_one("mh", 2, bus_mh.fifo_sel_res_final, bus_mh.sel_onehot, bus_mh.sel_new);
`ifdef FIFO_SEL_STATS_EN
        checkOutput("rr_grant_cnt", 32'(bus_rr.grant_cnt), e_cnt[0]);
        checkOutput("mh_grant_cnt", 32'(bus_mh.grant_cnt), e_cnt[2]);
        checkOutput("mh_preempt", 32'(bus_mh.preempt_flag), e_pre[2]);
        checkOutput("rr_preempt", 32'(bus_rr.preempt_flag), e_pre[0]);
`endif
    endtask

    task automatic applyStimulus(input logic [N-1:0] b, input logic r, input logic s);
        bits = b;
        rel  = r;
        rst  = s;
        model_step(b, r, s);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("reset_res", 32'(bus_rr.fifo_sel_res_final), 32'h00);
        checkOutput("reset_onehot", 32'(bus_rr.sel_onehot), 32'h0);

        // Grant holds while other bits toggle, then moves on after one idle cycle.
        applyStimulus(4'b0110, 1'b0, 1'b0);
        checkOutput("plan1_res", 32'(bus_rr.fifo_sel_res_final), 32'h81);
        checkOutput("plan1_onehot", 32'(bus_rr.sel_onehot), 32'h2);
        checkOutput("plan1_new", 32'(bus_rr.sel_new), 32'h1);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        checkOutput("plan1_hold", 32'(bus_rr.fifo_sel_res_final), 32'h81);
        checkOutput("plan1_new_low", 32'(bus_rr.sel_new), 32'h0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("plan2_gap", 32'(bus_rr.fifo_sel_res_final), 32'h00);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("plan2_next", 32'(bus_rr.fifo_sel_res_final), 32'h82);
        checkOutput("plan2_new", 32'(bus_rr.sel_new), 32'h1);

        // Release on the first cycle of every grant.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(4'b1111, (k % 2) == 1, 1'b0);
            checkOutput("plan3_rr_seq", 32'(bus_rr.fifo_sel_res_final), seq_rr[k]);
            checkOutput("plan3_fp_seq", 32'(bus_fp.fifo_sel_res_final), seq_fp[k]);
        end

        // Pre-emption after MAX_HOLD cycles with a competing request.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(4'b0011, 1'b0, 1'b0);
            checkOutput("plan4_mh_seq", 32'(bus_mh.fifo_sel_res_final), seq_mh[k]);
            checkOutput("plan4_rr_hold", 32'(bus_rr.fifo_sel_res_final), 32'h80);
        end

        // Reset in the middle of a grant, then rr_ptr restarts at 0.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("plan5_grant", 32'(bus_rr.fifo_sel_res_final), 32'h83);
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkOutput("plan5_rst_res", 32'(bus_rr.fifo_sel_res_final), 32'h00);
        checkOutput("plan5_rst_onehot", 32'(bus_rr.sel_onehot), 32'h0);
        checkOutput("plan5_rst_new", 32'(bus_rr.sel_new), 32'h0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("plan5_after", 32'(bus_rr.fifo_sel_res_final), 32'h80);

        // Release while idle is ignored.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("plan6_idle", 32'(bus_rr.fifo_sel_res_final), 32'h00);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("plan6_grant", 32'(bus_rr.fifo_sel_res_final), 32'h83);

        // Random traffic: requests mostly persist, occasional release and reset.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] b;
            b = bits;
            if ($urandom_range(3) == 0) b = N'($urandom);
            applyStimulus(b, $urandom_range(5) == 0, $urandom_range(63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
